warp_fetch_queue: RTL and testbench
===================================

WARP_FETCH_QUEUE -- requirements
Module: warp_fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of instruction entries; SHALL be a power of two and at least 4.
REQ-002 Port: i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: i_rst  input  1  synchronous, active-high reset.
REQ-004 Port: i_flush  input  1  discard all queued instructions (branch redirect).
REQ-005 Port: i_input_valid  input  1  fetch bundle valid.
REQ-006 Port: o_input_ready  output  1  queue can accept a bundle.
REQ-007 Port: i_inst0, i_inst1  input  32 each  fetched instructions, program order.
REQ-008 Port: i_compressed  input  2  per-instruction RVC flag; bit 0 belongs to inst0, bit 1 to inst1.
REQ-009 Port: i_count  input  1  0 = only inst0 valid; 1 = inst0 and inst1 valid.
REQ-010 Port: o_output_valid  output  1  at least one instruction presented.
REQ-011 Port: i_output_ready  input  1  decode accepts the presented instructions.
REQ-012 Port: o_inst0, o_inst1  output  32 each  oldest and second-oldest queued instruction.
REQ-013 Port: o_compressed  output  2  RVC flags matching o_inst0/o_inst1.
REQ-014 Port: o_count  output  1  0 = only o_inst0 valid; 1 = both valid.
REQ-015 Port: o_occupancy  output  clog2(DEPTH)+1  current number of queued entries.

Function
REQ-016 Storage: circular buffer of DEPTH entries, each {32-bit inst, 1-bit compressed}; read/write pointers of clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-017 Enqueue handshake: accepted = i_input_valid && o_input_ready; enqueues 1 entry (i_count=0) or 2 entries (i_count=1), inst0 before inst1.
REQ-018 o_input_ready SHALL be registered-state only: 1 iff occupancy <= DEPTH-2; same-cycle dequeue SHALL NOT be considered.
REQ-019 Dequeue handshake: sent = o_output_valid && i_output_ready; removes 2 entries if o_count=1, else 1.
REQ-020 o_output_valid = (occupancy >= 1); o_count = (occupancy >= 2); both SHALL be functions of registered state only.
REQ-021 Latency: an accepted bundle SHALL appear on the outputs the cycle after acceptance at the earliest; no input-to-output combinational bypass.
REQ-022 Output lanes: o_inst0/o_compressed[0] = entry at read pointer; o_inst1/o_compressed[1] = entry at read pointer+1 (mod DEPTH); lanes not covered by occupancy SHALL drive zero.
REQ-023 Simultaneous enqueue and dequeue in one cycle SHALL both take effect; new occupancy = occupancy + enq_n - deq_n.
REQ-024 Occupancy SHALL never exceed DEPTH nor go below 0; the ready/valid rules of REQ-018/REQ-020 guarantee this without further clamping.
REQ-025 Flush: i_flush SHALL set occupancy and both pointers to 0 next cycle and SHALL override any same-cycle enqueue and dequeue (accepted bundle discarded).
REQ-026 During a flush cycle, o_input_ready and o_output_valid SHALL still follow REQ-018/REQ-020 from pre-flush state; the upstream stage discards its side.
REQ-027 Pointer wrap: a two-entry enqueue or dequeue at pointer DEPTH-1 SHALL use entries DEPTH-1 and 0.
REQ-028 Output data SHALL remain stable while o_output_valid && !i_output_ready, unless i_flush or i_rst is asserted.

Reset
REQ-029 When i_rst=1 at a rising edge: occupancy, read and write pointers SHALL become 0; next cycle o_output_valid=0, o_count=0, o_input_ready=1, o_occupancy=0, all instruction and compressed outputs 0.
REQ-030 i_rst SHALL take priority over i_flush, enqueue and dequeue; storage contents are not reset.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries identically to REQ-029.

Verification
REQ-032 Reset then enqueue {inst0=0x00000013, inst1=0x00100093, count=1, compressed=00} with i_output_ready=0 -> next cycle o_output_valid=1, o_count=1, o_inst0=0x00000013, o_inst1=0x00100093, o_occupancy=2.
REQ-033 Enqueue four 2-instruction bundles, DEPTH=8, i_output_ready=0 -> after 3rd bundle o_input_ready=1 (occupancy 6); after 4th o_occupancy=8, o_input_ready=0; 5th bundle not accepted.
REQ-034 Occupancy 1, enqueue 2 and i_output_ready=1 in same cycle -> 1 dequeued, 2 enqueued, o_occupancy=2, order preserved.
REQ-035 Read pointer 7 with occupancy 2 (DEPTH=8) -> o_inst0=entry 7, o_inst1=entry 0; dequeue -> read pointer 1, occupancy 0.
REQ-036 Occupancy 5, i_flush=1 with i_input_valid=1 and i_output_ready=1 -> next cycle o_occupancy=0, o_output_valid=0, o_input_ready=1; flushed bundle never appears.
REQ-037 Compressed mix: enqueue count=1, compressed=01 -> o_compressed=01 on output; single-entry bundle count=0 -> o_count=0 while occupancy 1, o_inst1=0.

Source files
------------

// File: rtl/warp_fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// A circular buffer that accepts up to two instructions per cycle and presents the two oldest.
module warp_fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_input_valid,
    output logic                     o_input_ready,
    input  logic [31:0]              i_inst0,
    input  logic [31:0]              i_inst1,
    input  logic [1:0]               i_compressed,
    input  logic                     i_count,
    output logic                     o_output_valid,
    input  logic                     i_output_ready,
    output logic [31:0]              o_inst0,
    output logic [31:0]              o_inst1,
    output logic [1:0]               o_compressed,
    output logic                     o_count,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    localparam logic [OW-1:0] OCC_ONE   = OW'(1);
    localparam logic [OW-1:0] OCC_TWO   = OW'(2);
    localparam logic [OW-1:0] READY_MAX = OW'(DEPTH - 2);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_TWO   = AW'(2);

    logic [31:0]      mem_inst [DEPTH];
    logic [DEPTH-1:0] mem_rvc;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [OW-1:0] occ;

    logic [AW-1:0] rd_ptr_p1;
    logic [AW-1:0] wr_ptr_p1;
    logic          enq_fire;
    logic          deq_fire;
    logic [OW-1:0] enq_n;
    logic [OW-1:0] deq_n;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Ready and valid are decoded from registered occupancy only, so neither side sees a
    // combinational path from the other; a bundle is visible on the outputs one cycle
    // after it is accepted at the earliest.
    always_comb begin
        o_input_ready  = (occ <= READY_MAX);
        o_output_valid = (occ >= OCC_ONE);
        o_count        = (occ >= OCC_TWO);
        o_occupancy    = occ;

        rd_ptr_p1 = rd_ptr + PTR_ONE;
        wr_ptr_p1 = wr_ptr + PTR_ONE;

        enq_fire = i_input_valid && o_input_ready;
        deq_fire = o_output_valid && i_output_ready;

        enq_n = '0;
        if (enq_fire) begin
            enq_n = i_count ? OCC_TWO : OCC_ONE;
        end
        deq_n = '0;
        if (deq_fire) begin
            deq_n = o_count ? OCC_TWO : OCC_ONE;
        end
    end

    // Storage is never reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (enq_fire && !i_rst && !i_flush) begin
            mem_inst[wr_ptr] <= i_inst0;
            mem_rvc[wr_ptr]  <= i_compressed[0];
            if (i_count) begin
                mem_inst[wr_ptr_p1] <= i_inst1;
                mem_rvc[wr_ptr_p1]  <= i_compressed[1];
            end
        end
    end

    // Reset outranks flush, and flush outranks any same-cycle enqueue or dequeue.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + (i_count ? PTR_TWO : PTR_ONE);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + (o_count ? PTR_TWO : PTR_ONE);
            end
            occ <= occ + enq_n - deq_n;
        end
    end

    // Lanes beyond the current occupancy are forced to zero.
    always_comb begin
        o_inst0      = o_output_valid ? mem_inst[rd_ptr] : 32'd0;
        o_inst1      = o_count ? mem_inst[rd_ptr_p1] : 32'd0;
        o_compressed = {o_count & mem_rvc[rd_ptr_p1], o_output_valid & mem_rvc[rd_ptr]};
    end

endmodule

// File: tb/tb_warp_fetch_queue.sv
// Directed bench for warp_fetch_queue (DEPTH=8): reset, ordering, full/empty limits,
// simultaneous enqueue/dequeue, pointer wrap, flush and compressed flags.
module tb_warp_fetch_queue;

    logic        i_clk;
    logic        i_rst;
    logic        i_flush;
    logic        i_input_valid;
    logic        o_input_ready;
    logic [31:0] i_inst0;
    logic [31:0] i_inst1;
    logic [1:0]  i_compressed;
    logic        i_count;
    logic        o_output_valid;
    logic        i_output_ready;
    logic [31:0] o_inst0;
    logic [31:0] o_inst1;
    logic [1:0]  o_compressed;
    logic        o_count;
    logic [3:0]  o_occupancy;

    int errors;
    int checks;

    warp_fetch_queue #(.DEPTH(8)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_flush        (i_flush),
        .i_input_valid  (i_input_valid),
        .o_input_ready  (o_input_ready),
        .i_inst0        (i_inst0),
        .i_inst1        (i_inst1),
        .i_compressed   (i_compressed),
        .i_count        (i_count),
        .o_output_valid (o_output_valid),
        .i_output_ready (i_output_ready),
        .o_inst0        (o_inst0),
        .o_inst1        (o_inst1),
        .o_compressed   (o_compressed),
        .o_count        (o_count),
        .o_occupancy    (o_occupancy)
    );

    // Clock and reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Driver tasks
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_flush        = 1'b0;
        i_input_valid  = 1'b0;
        i_inst0        = 32'd0;
        i_inst1        = 32'd0;
        i_compressed   = 2'b00;
        i_count        = 1'b0;
        i_output_ready = 1'b0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] c, input logic cnt);
        i_input_valid = 1'b1;
        i_inst0       = a;
        i_inst1       = b;
        i_compressed  = c;
        i_count       = cnt;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_output_valid); end
        checks++; if (o_count !== 1'b0) begin errors++; $display("FAIL reset_count got=%0b exp=0", o_count); end
        checks++; if (o_input_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_input_ready); end
        checks++; if (o_occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", o_occupancy); end
        checks++; if (o_inst0 !== 32'd0) begin errors++; $display("FAIL reset_inst0 got=%h exp=0", o_inst0); end
        checks++; if (o_inst1 !== 32'd0) begin errors++; $display("FAIL reset_inst1 got=%h exp=0", o_inst1); end
        checks++; if (o_compressed !== 2'b00) begin errors++; $display("FAIL reset_comp got=%b exp=00", o_compressed); end
    endtask

    task automatic test_basic();
        do_reset();
        drive(32'h0000_0013, 32'h0010_0093, 2'b00, 1'b1);
        #1;
        checks++; if (o_output_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got=%0b exp=0", o_output_valid); end
        step();
        idle();
        checks++; if (o_output_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", o_output_valid); end
        checks++; if (o_count !== 1'b1) begin errors++; $display("FAIL basic_count got=%0b exp=1", o_count); end
        checks++; if (o_inst0 !== 32'h0000_0013) begin errors++; $display("FAIL basic_inst0 got=%h exp=00000013", o_inst0); end
        checks++; if (o_inst1 !== 32'h0010_0093) begin errors++; $display("FAIL basic_inst1 got=%h exp=00100093", o_inst1); end
        checks++; if (o_occupancy !== 4'd2) begin errors++; $display("FAIL basic_occ got=%0d exp=2", o_occupancy); end
        i_output_ready = 1'b1;
        step();
        idle();
        checks++; if (o_occupancy !== 4'd0) begin errors++; $display("FAIL basic_drain_occ got=%0d exp=0", o_occupancy); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(32'h1000_0000 + 32'(2 * k), 32'h1000_0000 + 32'(2 * k + 1), 2'b00, 1'b1);
            step();
            if (k == 2) begin
                checks++; if (o_occupancy !== 4'd6) begin errors++; $display("FAIL fill3_occ got=%0d exp=6", o_occupancy); end
                checks++; if (o_input_ready !== 1'b1) begin errors++; $display("FAIL fill3_ready got=%0b exp=1", o_input_ready); end
            end
        end
        checks++; if (o_occupancy !== 4'd8) begin errors++; $display("FAIL fill4_occ got=%0d exp=8", o_occupancy); end
        checks++; if (o_input_ready !== 1'b0) begin errors++; $display("FAIL fill4_ready got=%0b exp=0", o_input_ready); end
        drive(32'hDEAD_0000, 32'hDEAD_0001, 2'b11, 1'b1);
        step();
        idle();
        checks++; if (o_occupancy !== 4'd8) begin errors++; $display("FAIL fill5_occ got=%0d exp=8", o_occupancy); end
        checks++; if (o_inst0 !== 32'h1000_0000) begin errors++; $display("FAIL fill_hold_inst0 got=%h exp=10000000", o_inst0); end
        i_output_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (o_inst0 !== 32'h1000_0000 + 32'(2 * k)) begin errors++; $display("FAIL drain%0d_inst0 got=%h exp=%h", k, o_inst0, 32'h1000_0000 + 32'(2 * k)); end
            checks++; if (o_inst1 !== 32'h1000_0000 + 32'(2 * k + 1)) begin errors++; $display("FAIL drain%0d_inst1 got=%h exp=%h", k, o_inst1, 32'h1000_0000 + 32'(2 * k + 1)); end
            step();
        end
        idle();
        checks++; if (o_occupancy !== 4'd0) begin errors++; $display("FAIL drain_occ got=%0d exp=0", o_occupancy); end
        checks++; if (o_output_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%0b exp=0", o_output_valid); end
    endtask

    task automatic test_simul();
        do_reset();
        drive(32'hAAAA_0001, 32'hFFFF_FFFF, 2'b00, 1'b0);
        step();
        idle();
        checks++; if (o_occupancy !== 4'd1) begin errors++; $display("FAIL single_occ got=%0d exp=1", o_occupancy); end
        checks++; if (o_count !== 1'b0) begin errors++; $display("FAIL single_count got=%0b exp=0", o_count); end
        checks++; if (o_inst1 !== 32'd0) begin errors++; $display("FAIL single_inst1 got=%h exp=0", o_inst1); end
        drive(32'hBBBB_0002, 32'hCCCC_0003, 2'b00, 1'b1);
        i_output_ready = 1'b1;
        #1;
        checks++; if (o_inst0 !== 32'hAAAA_0001) begin errors++; $display("FAIL simul_pre_inst0 got=%h exp=aaaa0001", o_inst0); end
        step();
        idle();
        checks++; if (o_occupancy !== 4'd2) begin errors++; $display("FAIL simul_occ got=%0d exp=2", o_occupancy); end
        checks++; if (o_inst0 !== 32'hBBBB_0002) begin errors++; $display("FAIL simul_inst0 got=%h exp=bbbb0002", o_inst0); end
        checks++; if (o_inst1 !== 32'hCCCC_0003) begin errors++; $display("FAIL simul_inst1 got=%h exp=cccc0003", o_inst1); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(32'h5000_0000 + 32'(k), 32'd0, 2'b00, 1'b0);
            step();
            idle();
            i_output_ready = 1'b1;
            step();
            idle();
        end
        checks++; if (o_occupancy !== 4'd0) begin errors++; $display("FAIL wrap_pre_occ got=%0d exp=0", o_occupancy); end
        drive(32'h7777_0007, 32'h7777_0000, 2'b10, 1'b1);
        step();
        idle();
        checks++; if (o_occupancy !== 4'd2) begin errors++; $display("FAIL wrap_occ got=%0d exp=2", o_occupancy); end
        checks++; if (o_inst0 !== 32'h7777_0007) begin errors++; $display("FAIL wrap_inst0 got=%h exp=77770007", o_inst0); end
        checks++; if (o_inst1 !== 32'h7777_0000) begin errors++; $display("FAIL wrap_inst1 got=%h exp=77770000", o_inst1); end
        checks++; if (o_compressed !== 2'b10) begin errors++; $display("FAIL wrap_comp got=%b exp=10", o_compressed); end
        i_output_ready = 1'b1;
        step();
        idle();
        checks++; if (o_occupancy !== 4'd0) begin errors++; $display("FAIL wrap_deq_occ got=%0d exp=0", o_occupancy); end
        drive(32'h7777_0101, 32'd0, 2'b00, 1'b0);
        step();
        idle();
        checks++; if (o_inst0 !== 32'h7777_0101) begin errors++; $display("FAIL wrap_after_inst0 got=%h exp=77770101", o_inst0); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(32'h2000_0000, 32'h2000_0001, 2'b00, 1'b1);
        step();
        drive(32'h2000_0002, 32'h2000_0003, 2'b00, 1'b1);
        step();
        drive(32'h2000_0004, 32'd0, 2'b00, 1'b0);
        step();
        idle();
        checks++; if (o_occupancy !== 4'd5) begin errors++; $display("FAIL flush_pre_occ got=%0d exp=5", o_occupancy); end
        drive(32'hF1F1_F1F1, 32'hF2F2_F2F2, 2'b11, 1'b1);
        i_flush        = 1'b1;
        i_output_ready = 1'b1;
        #1;
        checks++; if (o_input_ready !== 1'b1) begin errors++; $display("FAIL flush_cycle_ready got=%0b exp=1", o_input_ready); end
        checks++; if (o_output_valid !== 1'b1) begin errors++; $display("FAIL flush_cycle_valid got=%0b exp=1", o_output_valid); end
        step();
        idle();
        checks++; if (o_occupancy !== 4'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", o_occupancy); end
        checks++; if (o_output_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", o_output_valid); end
        checks++; if (o_input_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0b exp=1", o_input_ready); end
        step();
        checks++; if (o_occupancy !== 4'd0) begin errors++; $display("FAIL flush_later_occ got=%0d exp=0", o_occupancy); end
        drive(32'h3000_0001, 32'd0, 2'b00, 1'b0);
        step();
        idle();
        checks++; if (o_inst0 !== 32'h3000_0001) begin errors++; $display("FAIL flush_next_inst0 got=%h exp=30000001", o_inst0); end
    endtask

    task automatic test_compressed();
        do_reset();
        drive(32'h0000_4501, 32'h0000_0513, 2'b01, 1'b1);
        step();
        drive(32'h0000_4505, 32'd0, 2'b01, 1'b0);
        step();
        idle();
        checks++; if (o_compressed !== 2'b01) begin errors++; $display("FAIL comp_mix got=%b exp=01", o_compressed); end
        i_output_ready = 1'b1;
        step();
        idle();
        checks++; if (o_count !== 1'b0) begin errors++; $display("FAIL comp_single_count got=%0b exp=0", o_count); end
        checks++; if (o_inst0 !== 32'h0000_4505) begin errors++; $display("FAIL comp_single_inst0 got=%h exp=00004505", o_inst0); end
        checks++; if (o_inst1 !== 32'd0) begin errors++; $display("FAIL comp_single_inst1 got=%h exp=0", o_inst1); end
        checks++; if (o_compressed !== 2'b01) begin errors++; $display("FAIL comp_single got=%b exp=01", o_compressed); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(32'h4000_0000, 32'h4000_0001, 2'b11, 1'b1);
        step();
        drive(32'h4000_0002, 32'h4000_0003, 2'b11, 1'b1);
        i_flush        = 1'b0;
        i_output_ready = 1'b1;
        i_rst          = 1'b1;
        step();
        i_rst = 1'b0;
        idle();
        checks++; if (o_occupancy !== 4'd0) begin errors++; $display("FAIL midrst_occ got=%0d exp=0", o_occupancy); end
        checks++; if (o_output_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", o_output_valid); end
        checks++; if (o_inst0 !== 32'd0) begin errors++; $display("FAIL midrst_inst0 got=%h exp=0", o_inst0); end
        checks++; if (o_compressed !== 2'b00) begin errors++; $display("FAIL midrst_comp got=%b exp=00", o_compressed); end
    endtask

    // Sequence and final report
    initial begin
        errors = 0;
        checks = 0;
        i_rst  = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_fill();
        test_simul();
        test_wrap();
        test_flush();
        test_compressed();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
